// File: rtl/dac_spi_receiver.sv
// Serial-to-parallel receiver for the 16-bit DAC link (MSB first) with dav/ack handshake.
// Optional frame-length checking is enabled by defining RCV_FRAMECHK_EN.
module dac_spi_receiver (
    input  logic        rcvclk,
    input  logic        rcvrst,
    input  logic        rcvcs,
    input  logic        rcvsck,
    input  logic        rcvdin,
    input  logic        rcvack,
    output logic [15:0] rcvdata,
    output logic        rcvdav,
    output logic        rcvovr,
    output logic        rcvferr
);

    typedef enum logic [1:0] {StWait, StIdle, StShift} state_e;

    state_e      state_q, state_d;
    logic        cs_s1, cs_s2, cs_s3;
    logic        sck_s1, sck_s2, sck_s3;
    logic        din_s1, din_s2;
    logic [1:0]  settle_q, settle_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] data_q, data_d;
    logic        dav_q, dav_d;
    logic        ovr_q, ovr_d;
    logic        frame_end, accept;
    logic        cs_rise, cs_fall, sck_rise;

    assign cs_rise  = cs_s2 & ~cs_s3;
    assign cs_fall  = ~cs_s2 & cs_s3;
    assign sck_rise = sck_s2 & ~sck_s3;

    always_ff @(posedge rcvclk) begin
        if (rcvrst) begin
            state_q  <= StWait;
            {cs_s1, cs_s2, cs_s3}    <= 3'b111;
            {sck_s1, sck_s2, sck_s3} <= 3'b000;
            {din_s1, din_s2}         <= 2'b00;
            settle_q <= 2'd0;
            shift_q  <= 16'h0000;
            cnt_q    <= 5'd0;
            data_q   <= 16'h0000;
            dav_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            {cs_s1, cs_s2, cs_s3}    <= {rcvcs, cs_s1, cs_s2};
            {sck_s1, sck_s2, sck_s3} <= {rcvsck, sck_s1, sck_s2};
            {din_s1, din_s2}         <= {rcvdin, din_s1};
            settle_q <= settle_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            dav_q    <= dav_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        frame_end = 1'b0;
        // Synchronizers come out of reset holding cs high; wait until the pin has
        // propagated through them so a frame already in progress is not mistaken for idle.
        settle_d  = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        unique case (state_q)
            StWait: begin
                if (settle_q[1] && cs_s2) state_d = StIdle;
            end
            StIdle: begin
                if (cs_fall) begin
                    state_d = StShift;
                    shift_d = 16'h0000;
                    cnt_d   = 5'd0;
                end
            end
            StShift: begin
                if (cs_rise) begin
                    state_d   = StIdle;
                    frame_end = 1'b1;
                end else if (sck_rise) begin
                    shift_d = {shift_q[14:0], din_s2};
                    if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = StWait;
        endcase
    end

`ifdef RCV_FRAMECHK_EN
    logic ferr_q;

    always_ff @(posedge rcvclk) begin
        if (rcvrst) ferr_q <= 1'b0;
        else        ferr_q <= frame_end && (cnt_q != 5'd16);
    end

    assign accept  = frame_end && (cnt_q == 5'd16);
    assign rcvferr = ferr_q;
`else
    assign accept  = frame_end && (cnt_q != 5'd0);
    assign rcvferr = 1'b0;
`endif

    // A new word outranks a coincident ack: dav stays up and no overrun is flagged.
    always_comb begin
        data_d = data_q;
        dav_d  = dav_q;
        ovr_d  = ovr_q;
        if (accept) begin
            data_d = shift_q;
            dav_d  = 1'b1;
        end else if (rcvack && dav_q) begin
            dav_d = 1'b0;
        end
        if (rcvack && dav_q)       ovr_d = 1'b0;
        else if (accept && dav_q)  ovr_d = 1'b1;
    end

    assign rcvdata = data_q;
    assign rcvdav  = dav_q;
    assign rcvovr  = ovr_q;

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Directed bench for dac_spi_receiver; honours RCV_FRAMECHK_EN for the frame-length test.
module tb_dac_spi_receiver;

    logic        rcvclk, rcvrst, rcvcs, rcvsck, rcvdin, rcvack;
    logic [15:0] rcvdata;
    logic        rcvdav, rcvovr, rcvferr;
    int          vectors = 0;
    int          miscompares = 0;
    int          ferr_cnt = 0;

    dac_spi_receiver dut (
        .rcvclk  (rcvclk),
        .rcvrst  (rcvrst),
        .rcvcs   (rcvcs),
        .rcvsck  (rcvsck),
        .rcvdin  (rcvdin),
        .rcvack  (rcvack),
        .rcvdata (rcvdata),
        .rcvdav  (rcvdav),
        .rcvovr  (rcvovr),
        .rcvferr (rcvferr)
    );

    initial rcvclk = 1'b0;
    always #5 rcvclk = ~rcvclk;

    always @(negedge rcvclk) if (rcvferr === 1'b1) ferr_cnt <= ferr_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at 1 ms");
        $fatal(1, "watchdog");
    end

    task automatic send_bits(input logic [31:0] word, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            rcvsck = 1'b0;
            rcvdin = word[i];
            repeat (5) @(negedge rcvclk);
            rcvsck = 1'b1;
            repeat (5) @(negedge rcvclk);
        end
        rcvsck = 1'b0;
        repeat (5) @(negedge rcvclk);
    endtask

    task automatic start_frame();
        @(negedge rcvclk);
        rcvcs = 1'b0;
        repeat (4) @(negedge rcvclk);
    endtask

    task automatic end_frame();
        rcvcs = 1'b1;
        repeat (6) @(negedge rcvclk);
    endtask

    task automatic pulse_ack();
        @(negedge rcvclk);
        rcvack = 1'b1;
        @(negedge rcvclk);
        rcvack = 1'b0;
    endtask

    task automatic test_reset();
        rcvrst = 1'b1;
        rcvcs  = 1'b1;
        rcvsck = 1'b0;
        rcvdin = 1'b0;
        rcvack = 1'b0;
        repeat (3) @(negedge rcvclk);
        rcvrst = 1'b0;
        repeat (5) @(negedge rcvclk);
        vectors++;
        if ({rcvdata, rcvdav, rcvovr, rcvferr} !== {16'h0000, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_outputs: got data=%h dav=%b ovr=%b ferr=%b want 0000/0/0/0",
                     rcvdata, rcvdav, rcvovr, rcvferr);
        end
    endtask

    task automatic test_single();
        start_frame();
        send_bits(32'h0000A5C3, 16);
        rcvcs = 1'b1;
        repeat (2) @(posedge rcvclk);
        #1;
        vectors++;
        if (rcvdav !== 1'b0) begin
            miscompares++;
            $display("FAIL single_dav_edge2: got %b want 0", rcvdav);
        end
        @(posedge rcvclk);
        #1;
        vectors++;
        if (rcvdav !== 1'b1 || rcvdata !== 16'hA5C3) begin
            miscompares++;
            $display("FAIL single_edge3: got dav=%b data=%h want 1/a5c3", rcvdav, rcvdata);
        end
        repeat (4) @(negedge rcvclk);
        vectors++;
        if (rcvdav !== 1'b1) begin
            miscompares++;
            $display("FAIL single_dav_held: got %b want 1", rcvdav);
        end
        pulse_ack();
        vectors++;
        if (rcvdav !== 1'b0 || rcvovr !== 1'b0) begin
            miscompares++;
            $display("FAIL single_ack: got dav=%b ovr=%b want 0/0", rcvdav, rcvovr);
        end
    endtask

    task automatic test_overrun();
        start_frame();
        send_bits(32'h00001234, 16);
        rcvcs = 1'b1;
        repeat (2) @(negedge rcvclk);
        rcvcs = 1'b0;
        repeat (4) @(negedge rcvclk);
        send_bits(32'h0000BEEF, 16);
        end_frame();
        vectors++;
        if (rcvdata !== 16'hBEEF || rcvdav !== 1'b1 || rcvovr !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun: got data=%h dav=%b ovr=%b want beef/1/1",
                     rcvdata, rcvdav, rcvovr);
        end
        pulse_ack();
        vectors++;
        if (rcvdav !== 1'b0 || rcvovr !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_ack: got dav=%b ovr=%b want 0/0", rcvdav, rcvovr);
        end
    endtask

    task automatic test_ack_coincide();
        start_frame();
        send_bits(32'h00001111, 16);
        end_frame();
        vectors++;
        if (rcvdav !== 1'b1 || rcvdata !== 16'h1111) begin
            miscompares++;
            $display("FAIL coincide_pending: got dav=%b data=%h want 1/1111", rcvdav, rcvdata);
        end
        start_frame();
        send_bits(32'h000000FF, 16);
        rcvcs = 1'b1;
        repeat (2) @(negedge rcvclk);
        rcvack = 1'b1;
        @(negedge rcvclk);
        rcvack = 1'b0;
        vectors++;
        if (rcvdata !== 16'h00FF || rcvdav !== 1'b1 || rcvovr !== 1'b0) begin
            miscompares++;
            $display("FAIL coincide: got data=%h dav=%b ovr=%b want 00ff/1/0",
                     rcvdata, rcvdav, rcvovr);
        end
        repeat (3) @(negedge rcvclk);
        pulse_ack();
        vectors++;
        if (rcvdav !== 1'b0) begin
            miscompares++;
            $display("FAIL coincide_ack: got dav=%b want 0", rcvdav);
        end
    endtask

    task automatic test_reset_midframe();
        int ferr_start;
        ferr_start = ferr_cnt;
        start_frame();
        send_bits(32'h000000C3, 8);
        @(negedge rcvclk);
        rcvrst = 1'b1;
        repeat (2) @(negedge rcvclk);
        rcvrst = 1'b0;
        send_bits(32'h0000005A, 8);
        end_frame();
        vectors++;
        if (rcvdav !== 1'b0 || rcvdata !== 16'h0000 || rcvovr !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_truncated: got dav=%b data=%h ovr=%b want 0/0000/0",
                     rcvdav, rcvdata, rcvovr);
        end
        start_frame();
        send_bits(32'h00000001, 16);
        end_frame();
        vectors++;
        if (rcvdav !== 1'b1 || rcvdata !== 16'h0001) begin
            miscompares++;
            $display("FAIL midreset_next: got dav=%b data=%h want 1/0001", rcvdav, rcvdata);
        end
        vectors++;
        if (ferr_cnt !== ferr_start) begin
            miscompares++;
            $display("FAIL midreset_ferr: got %0d pulses want 0", ferr_cnt - ferr_start);
        end
        pulse_ack();
    endtask

    task automatic test_frame_length();
        int ferr_start;
        ferr_start = ferr_cnt;
        start_frame();
`ifdef RCV_FRAMECHK_EN
        send_bits(32'h00007FFF, 15);
        rcvcs = 1'b1;
        repeat (2) @(negedge rcvclk);
        vectors++;
        if (rcvferr !== 1'b0) begin
            miscompares++;
            $display("FAIL short_ferr_early: got %b want 0", rcvferr);
        end
        @(negedge rcvclk);
        vectors++;
        if (rcvferr !== 1'b1) begin
            miscompares++;
            $display("FAIL short_ferr_pulse: got %b want 1", rcvferr);
        end
        @(negedge rcvclk);
        vectors++;
        if (rcvferr !== 1'b0) begin
            miscompares++;
            $display("FAIL short_ferr_width: got %b want 0", rcvferr);
        end
        repeat (3) @(negedge rcvclk);
        vectors++;
        if (rcvdav !== 1'b0 || rcvdata !== 16'h0001 || ferr_cnt - ferr_start !== 1) begin
            miscompares++;
            $display("FAIL short_frame: got dav=%b data=%h pulses=%0d want 0/0001/1",
                     rcvdav, rcvdata, ferr_cnt - ferr_start);
        end
`else
        send_bits(32'h0005CAFE, 20);
        end_frame();
        vectors++;
        if (rcvdav !== 1'b1 || rcvdata !== 16'hCAFE || ferr_cnt !== ferr_start) begin
            miscompares++;
            $display("FAIL long_frame: got dav=%b data=%h pulses=%0d want 1/cafe/0",
                     rcvdav, rcvdata, ferr_cnt - ferr_start);
        end
        pulse_ack();
`endif
    endtask

    task automatic test_sck_while_idle();
        int ferr_start;
        ferr_start = ferr_cnt;
        for (int i = 0; i < 5; i++) begin
            rcvsck = 1'b1;
            rcvdin = 1'b1;
            repeat (5) @(negedge rcvclk);
            rcvsck = 1'b0;
            repeat (5) @(negedge rcvclk);
        end
        vectors++;
        if (rcvdav !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_sck_nodeliver: got dav=%b want 0", rcvdav);
        end
        start_frame();
        send_bits(32'h00008001, 16);
        end_frame();
        vectors++;
        if (rcvdav !== 1'b1 || rcvdata !== 16'h8001 || rcvovr !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_sck_frame: got dav=%b data=%h ovr=%b want 1/8001/0",
                     rcvdav, rcvdata, rcvovr);
        end
        vectors++;
        if (ferr_cnt !== ferr_start) begin
            miscompares++;
            $display("FAIL idle_sck_ferr: got %0d pulses want 0", ferr_cnt - ferr_start);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_ack_coincide();
        test_reset_midframe();
        test_frame_length();
        test_sck_while_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
